// File: rtl/minimig_zorro_decode_if.sv
// Purpose: bundles the autoconfig write port, CPU request/address and decode results of minimig_zorro_decode.
// Latency: wires only; timing is set by the decoder (1 cycle from request to sel_*/hit_valid).
// Backpressure: none; the decoder accepts every qualified write/request, so there is no ready.
interface minimig_zorro_decode_if;
    logic        clk7_en;
    logic        ac_sel;
    logic [6:0]  ac_address;        // autoconfig register address bits [7:1]
    logic        hwr;
    logic        lwr;
    logic [15:0] data_in;
    logic [2:0]  board_configured;  // bit0 ZII RAM, bit1 ZIII RAM
    logic [1:0]  fastram_config;    // 00 off, 01 2 MB, 10 4 MB, 11 8 MB
    logic        cpu_req;
    logic [30:0] cpu_address;       // CPU address bits [31:1]
    logic [7:0]  base_zii;          // A23..A16
    logic [7:0]  base_ziii;         // A31..A24
    logic        sel_zii;
    logic        sel_ziii;
    logic        hit_valid;

    // Driver side: CPU / autoconfig logic
    modport master (
        output clk7_en, ac_sel, ac_address, hwr, lwr, data_in,
               board_configured, fastram_config, cpu_req, cpu_address,
        input  base_zii, base_ziii, sel_zii, sel_ziii, hit_valid
    );

    // Decoder side
    modport slave (
        input  clk7_en, ac_sel, ac_address, hwr, lwr, data_in,
               board_configured, fastram_config, cpu_req, cpu_address,
        output base_zii, base_ziii, sel_zii, sel_ziii, hit_valid
    );
endinterface

// File: rtl/minimig_zorro_decode.sv
// Purpose: captures Zorro base addresses from autoconfig writes, commits them on board_configured rises, decodes CPU hits.
// Latency: decode registered, sel_*/hit_valid valid 1 cycle after a sampled request; base commits 1 cycle after the edge.
// Backpressure: none; every write/request qualified by clk7_en is taken. ZIII support is built with MINIMIG_ZORRO3_DECODE_EN.
module minimig_zorro_decode (
    input  logic                         clk,
    input  logic                         _reset,
    minimig_zorro_decode_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LO_SEEN = 2'd1,
        ST_ARMED   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_state_post_commit;
    logic [3:0]  r_pend_lo;
    logic [3:0]  r_pend_hi;
    logic [3:0]  w_pend_lo_nxt;
    logic [3:0]  w_pend_hi_nxt;
    logic [7:0]  r_base_zii;
    logic [7:0]  w_base_zii_nxt;
    logic [2:0]  r_bc_q;
    logic        r_post_rst;
    logic        r_sel_zii;
    logic        r_hit_valid;

    logic        w_cfg_wr;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_commit_zii;
    logic        w_req;
    logic [7:0]  w_a_top;
    logic [3:0]  w_a_nib;
    logic [4:0]  w_zii_n;
    logic [4:0]  w_zii_upper;
    logic        w_zii_hit;

    // Config writes are only meaningful on 7 MHz enable cycles with the autoconfig space selected.
    assign w_cfg_wr = bus.clk7_en & bus.ac_sel & (bus.hwr | bus.lwr);
    assign w_wr_lo  = w_cfg_wr & (bus.ac_address == 7'h25);   // byte address 0x4A
    assign w_wr_hi  = w_cfg_wr & (bus.ac_address == 7'h24);   // byte address 0x48

    // The first cycle after reset is masked so a board_configured already high is not mistaken for a rise.
    assign w_commit_zii = bus.board_configured[0] & ~r_bc_q[0] & ~r_post_rst;

    // A commit happens "before" a same-cycle write: the write sees the post-commit state.
    assign w_state_post_commit = w_commit_zii ? ST_IDLE : r_state;

    // Next-state, pending and ZII base updates.
    always_comb begin
        w_state_nxt    = w_state_post_commit;
        w_pend_lo_nxt  = r_pend_lo;
        w_pend_hi_nxt  = r_pend_hi;
        w_base_zii_nxt = r_base_zii;
        if (w_commit_zii) begin
            w_base_zii_nxt = {r_pend_hi, r_pend_lo};
        end
        if (w_wr_lo) begin
            w_pend_lo_nxt = bus.data_in[15:12];
            w_state_nxt   = ST_LO_SEEN;
        end else if (w_wr_hi) begin
            w_pend_hi_nxt = bus.data_in[15:12];
            w_state_nxt   = ST_ARMED;
            // A lone 0x48 write means the low nibble was never written this round.
            if (w_state_post_commit == ST_IDLE) begin
                w_pend_lo_nxt = 4'h0;
            end
        end
    end

    // ZII window: base nibble up to base+N-1 in 5 bits so a window near the top never wraps to 0.
    assign w_req   = bus.cpu_req & bus.clk7_en;
    assign w_a_top = bus.cpu_address[30:23];    // A31..A24
    assign w_a_nib = bus.cpu_address[22:19];    // A23..A20

    always_comb begin
        case (bus.fastram_config)
            2'b01:   w_zii_n = 5'd2;
            2'b10:   w_zii_n = 5'd4;
            2'b11:   w_zii_n = 5'd8;
            default: w_zii_n = 5'd0;
        endcase
    end

    assign w_zii_upper = {1'b0, r_base_zii[7:4]} + w_zii_n - 5'd1;
    assign w_zii_hit   = bus.board_configured[0] & (bus.fastram_config != 2'b00) &
                         (w_a_top == 8'h00) & (w_a_nib >= r_base_zii[7:4]) &
                         ({1'b0, w_a_nib} <= w_zii_upper);

    // Config state, ZII base, edge-detect copy and registered decode.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_state     <= ST_IDLE;
            r_pend_lo   <= 4'h0;
            r_pend_hi   <= 4'h0;
            r_base_zii  <= 8'h00;
            r_bc_q      <= 3'b000;
            r_post_rst  <= 1'b1;
            r_sel_zii   <= 1'b0;
            r_hit_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_lo   <= w_pend_lo_nxt;
            r_pend_hi   <= w_pend_hi_nxt;
            r_base_zii  <= w_base_zii_nxt;
            r_bc_q      <= bus.board_configured;
            r_post_rst  <= 1'b0;
            r_hit_valid <= w_req;
            if (w_req) begin
                r_sel_zii <= w_zii_hit;
            end
        end
    end

    assign bus.base_zii  = r_base_zii;
    assign bus.sel_zii   = r_sel_zii;
    assign bus.hit_valid = r_hit_valid;

`ifdef MINIMIG_ZORRO3_DECODE_EN
    logic [7:0]  r_pend_z3;
    logic [7:0]  r_base_ziii;
    logic        r_sel_ziii;
    logic        w_wr_z3;
    logic        w_commit_ziii;
    logic        w_ziii_hit;
    logic        w_unused;

    assign w_wr_z3       = w_cfg_wr & (bus.ac_address == 7'h22);   // byte address 0x44
    assign w_commit_ziii = bus.board_configured[1] & ~r_bc_q[1] & ~r_post_rst;
    assign w_ziii_hit    = bus.board_configured[1] & (w_a_top == r_base_ziii);

    // ZIII pending/base capture and decode; ZII wins when both windows match.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_pend_z3   <= 8'h00;
            r_base_ziii <= 8'h00;
            r_sel_ziii  <= 1'b0;
        end else begin
            if (w_commit_ziii) begin
                r_base_ziii <= r_pend_z3;
            end
            if (w_wr_z3) begin
                r_pend_z3 <= bus.data_in[15:8];
            end
            if (w_req) begin
                r_sel_ziii <= w_ziii_hit & ~w_zii_hit;
            end
        end
    end

    assign bus.base_ziii = r_base_ziii;
    assign bus.sel_ziii  = r_sel_ziii;
    assign w_unused      = ^{bus.data_in[7:0], bus.cpu_address[18:0], r_bc_q[2]};
`else
    logic        w_unused;

    assign bus.base_ziii = 8'h00;
    assign bus.sel_ziii  = 1'b0;
    assign w_unused      = ^{bus.data_in[11:0], bus.cpu_address[18:0], r_bc_q[2:1]};
`endif

endmodule

// File: tb/tb_minimig_zorro_decode.sv
// Purpose: directed self-checking bench for minimig_zorro_decode (commit, decode windows, ordering, reset).
// Latency: expects bases 1 cycle after a board_configured rise and sel_*/hit_valid 1 cycle after a request.
// Backpressure: none exercised; the decoder has no stall path.
module tb_minimig_zorro_decode;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    minimig_zorro_decode_if bus ();

    minimig_zorro_decode dut (
        .clk    (clk),
        ._reset (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [15:0] d);
        logic [7:0] a;
        a              = addr;
        bus.ac_address = a[7:1];
        bus.data_in    = d;
        bus.ac_sel     = 1'b1;
        bus.hwr        = 1'b1;
        tick();
        bus.ac_sel     = 1'b0;
        bus.hwr        = 1'b0;
    endtask

    // Drops board_configured[0] for a cycle, raises it, and checks the committed ZII base.
    task automatic commit_zii(input string tag, input logic [7:0] exp_base);
        bus.board_configured[0] = 1'b0;
        tick();
        bus.board_configured[0] = 1'b1;
        tick();
        chk(tag, {24'h0, bus.base_zii}, {24'h0, exp_base});
    endtask

    task automatic request(input string tag, input logic [31:0] addr,
                           input logic exp_zii, input logic exp_ziii);
        logic [31:0] a;
        a               = addr;
        bus.cpu_address = a[31:1];
        bus.cpu_req     = 1'b1;
        tick();
        bus.cpu_req     = 1'b0;
        chk({tag, "_hv"},   {31'h0, bus.hit_valid}, 32'h1);
        chk({tag, "_zii"},  {31'h0, bus.sel_zii},   {31'h0, exp_zii});
        chk({tag, "_ziii"}, {31'h0, bus.sel_ziii},  {31'h0, exp_ziii});
        tick();
        chk({tag, "_hv_drop"},  {31'h0, bus.hit_valid}, 32'h0);
        chk({tag, "_zii_hold"}, {31'h0, bus.sel_zii},   {31'h0, exp_zii});
    endtask

    initial begin
        checks               = 0;
        failures             = 0;
        rst_n                = 1'b0;
        bus.clk7_en          = 1'b1;
        bus.ac_sel           = 1'b0;
        bus.ac_address       = 7'h00;
        bus.hwr              = 1'b0;
        bus.lwr              = 1'b0;
        bus.data_in          = 16'h0000;
        bus.board_configured = 3'b000;
        bus.fastram_config   = 2'b00;
        bus.cpu_req          = 1'b0;
        bus.cpu_address      = 31'h0;
        tick();
        tick();

        // Reset state
        chk("rst_base_zii",  {24'h0, bus.base_zii},  32'h0);
        chk("rst_base_ziii", {24'h0, bus.base_ziii}, 32'h0);
        chk("rst_sel_zii",   {31'h0, bus.sel_zii},   32'h0);
        chk("rst_sel_ziii",  {31'h0, bus.sel_ziii},  32'h0);
        chk("rst_hit_valid", {31'h0, bus.hit_valid}, 32'h0);
        rst_n = 1'b1;
        tick();

        // ZII commit: 0x4A=0x0000, 0x48=0x2000, then rise of board_configured[0]
        bus.fastram_config = 2'b10;
        cfg_write(8'h4A, 16'h0000);
        cfg_write(8'h48, 16'h2000);
        bus.board_configured = 3'b001;
        chk("commit_pre_edge", {24'h0, bus.base_zii}, 32'h0);
        tick();
        chk("commit_zii_20", {24'h0, bus.base_zii}, 32'h20);

        // ZII decode with base 0x20, 4 MB: window A[23:20] = 2..5
        request("zii_top_in",  32'h005F_FFFE, 1'b1, 1'b0);
        request("zii_above",   32'h0060_0000, 1'b0, 1'b0);
        request("zii_below",   32'h001F_FFFE, 1'b0, 1'b0);
        request("zii_low_bnd", 32'h0020_0000, 1'b1, 1'b0);

        // Writes and requests without clk7_en are ignored
        bus.clk7_en    = 1'b0;
        bus.ac_address = 7'h24;
        bus.data_in    = 16'hF000;
        bus.ac_sel     = 1'b1;
        bus.hwr        = 1'b1;
        bus.cpu_req    = 1'b1;
        bus.cpu_address = 31'h0;
        tick();
        bus.ac_sel     = 1'b0;
        bus.hwr        = 1'b0;
        bus.cpu_req    = 1'b0;
        chk("gated_req_hv", {31'h0, bus.hit_valid}, 32'h0);
        bus.clk7_en    = 1'b1;
        commit_zii("gated_write_base", 8'h20);

        // Low-byte strobe alone is a valid config write
        bus.ac_address = 7'h24;
        bus.data_in    = 16'h7000;
        bus.ac_sel     = 1'b1;
        bus.lwr        = 1'b1;
        tick();
        bus.ac_sel     = 1'b0;
        bus.lwr        = 1'b0;
        commit_zii("lwr_write_base", 8'h70);

        // Wrap edge: 8 MB at base 0xC0 spans C..F with no wrap past the 16 MB line
        cfg_write(8'h48, 16'hC000);
        bus.fastram_config = 2'b11;
        commit_zii("commit_c0", 8'hC0);
        request("wrap_top",    32'h00FF_FFFE, 1'b1, 1'b0);
        request("wrap_16mb",   32'h0100_0000, 1'b0, 1'b0);
        request("wrap_below",  32'h00BF_FFFE, 1'b0, 1'b0);
        bus.fastram_config = 2'b00;
        request("fast_off",    32'h00FF_FFFE, 1'b0, 1'b0);
        bus.fastram_config = 2'b11;

        // Full sequence keeps the low nibble; a lone 0x48 write clears it
        cfg_write(8'h4A, 16'h1000);
        cfg_write(8'h48, 16'h3000);
        commit_zii("commit_31", 8'h31);
        cfg_write(8'h48, 16'h4000);
        commit_zii("commit_lone_48", 8'h40);

        // Commit edge and 0x48 write in the same cycle: commit uses old pend_hi (4)
        bus.board_configured[0] = 1'b0;
        tick();
        bus.board_configured[0] = 1'b1;
        bus.ac_address = 7'h24;
        bus.data_in    = 16'h9000;
        bus.ac_sel     = 1'b1;
        bus.hwr        = 1'b1;
        tick();
        bus.ac_sel     = 1'b0;
        bus.hwr        = 1'b0;
        chk("simul_old_hi", {24'h0, bus.base_zii}, 32'h40);
        commit_zii("simul_new_hi", 8'h90);

`ifdef MINIMIG_ZORRO3_DECODE_EN
        // ZIII commit and decode
        cfg_write(8'h44, 16'h4000);
        bus.board_configured = 3'b011;
        tick();
        chk("ziii_base_40", {24'h0, bus.base_ziii}, 32'h40);
        request("ziii_hit", 32'h4012_3456, 1'b0, 1'b1);
        // Both windows match at base_ziii 0x00: ZII wins
        cfg_write(8'h44, 16'h0000);
        bus.board_configured[1] = 1'b0;
        tick();
        bus.board_configured[1] = 1'b1;
        tick();
        chk("ziii_base_00", {24'h0, bus.base_ziii}, 32'h0);
`else
        // Without ZIII support the 0x44 write and board_configured[1] have no effect
        cfg_write(8'h44, 16'h4000);
        bus.board_configured = 3'b011;
        tick();
        chk("ziii_off_base", {24'h0, bus.base_ziii}, 32'h0);
        request("ziii_off_req", 32'h4012_3456, 1'b0, 1'b0);
`endif
        request("zii_priority", 32'h0090_0000, 1'b1, 1'b0);

        // Reset while ARMED with board_configured[0] held high across reset release
        cfg_write(8'h48, 16'h3000);
        bus.board_configured = 3'b000;
        tick();
        bus.board_configured = 3'b001;
        rst_n = 1'b0;
        tick();
        chk("rst_armed_base", {24'h0, bus.base_zii}, 32'h0);
        chk("rst_armed_sel",  {31'h0, bus.sel_zii},  32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_commit", {24'h0, bus.base_zii}, 32'h0);
        tick();
        chk("post_rst_still_0", {24'h0, bus.base_zii}, 32'h0);
        bus.board_configured = 3'b000;
        tick();

        // Reset mid-config discards the 0x4A data
        cfg_write(8'h4A, 16'h5000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cfg_write(8'h48, 16'h2000);
        commit_zii("rst_mid_cfg", 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minimig_zorro_decode.md
MINIMIG_ZORRO_DECODE -- requirements
Module: minimig_zorro_decode

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have: _reset  in  1  synchronous, active-low reset.
REQ-003 SHALL have: clk7_en  in  1  7 MHz clock enable that qualifies CPU writes and requests.
REQ-004 SHALL have: ac_sel  in  1  autoconfig space select, same signal as the autoconfig block's sel.
REQ-005 SHALL have: ac_address  in  7  autoconfig register address bits [7:1].
REQ-006 SHALL have: hwr, lwr  in  1 each  CPU high/low byte write strobes.
REQ-007 SHALL have: data_in  in  16  CPU write data.
REQ-008 SHALL have: board_configured  in  3  per-board configured flags from the autoconfig block (bit0 ZII RAM, bit1 ZIII RAM).
REQ-009 SHALL have: fastram_config  in  2  ZII size: 00 off, 01 2 MB, 10 4 MB, 11 8 MB.
REQ-010 SHALL have: cpu_req  in  1  access request strobe, sampled only when clk7_en=1.
REQ-011 SHALL have: cpu_address  in  31  CPU address bits [31:1].
REQ-012 SHALL have: base_zii  out  8  committed ZII base, A23..A16.
REQ-013 SHALL have: base_ziii  out  8  committed ZIII base, A31..A24.
REQ-014 SHALL have: sel_zii, sel_ziii  out  1 each  registered decode hits.
REQ-015 SHALL have: hit_valid  out  1  one-cycle pulse marking sel_* as valid for the last sampled request.

Function
REQ-016 Config write SHALL mean clk7_en & ac_sel & (hwr|lwr); all other cycles SHALL leave pending registers unchanged.
REQ-017 A config write at 0x4A SHALL load pend_lo <= data_in[15:12] and set state LO_SEEN.
REQ-018 A config write at 0x48 SHALL load pend_hi <= data_in[15:12] and set state ARMED; from IDLE, pend_lo SHALL be forced to 0.
REQ-019 A config write at 0x44 SHALL load pend_z3 <= data_in[15:8] (ZORRO3_EN only).
REQ-020 State machine SHALL be IDLE -> LO_SEEN (0x4A) -> ARMED (0x48) -> IDLE (commit); 0x48 from IDLE SHALL go directly to ARMED.
REQ-021 A rising edge on board_configured[0] (detected against a one-cycle registered copy) SHALL commit base_zii <= {pend_hi,pend_lo} and return the state to IDLE.
REQ-022 A rising edge on board_configured[1] SHALL commit base_ziii <= pend_z3.
REQ-023 If a commit edge and a new config write fall in the same cycle, the commit SHALL use the pre-write pending value, and the write SHALL then update pending.
REQ-024 On a 0->1 rise of board_configured with the FSM in IDLE, the block SHALL still commit the current pending values.
REQ-025 On cpu_req & clk7_en, the block SHALL register the decode; sel_zii, sel_ziii and hit_valid SHALL be valid in the next cycle, with exactly 1 cycle of latency.
REQ-026 sel_zii SHALL assert when board_configured[0]=1, fastram_config!=00, cpu_address[31:24]=0, and base_zii[7:4] <= A[23:20] <= base_zii[7:4]+N-1, where N is 2/4/8; the upper bound SHALL be computed 5 bits wide with no wrap, so A[23:20] values above 0xF never match.
REQ-027 sel_ziii SHALL assert when board_configured[1]=1 and cpu_address[31:24]=base_ziii.
REQ-028 hit_valid SHALL be a single-cycle pulse; sel_* SHALL hold their value until the next sampled request.
REQ-029 sel_zii and sel_ziii SHALL never both be 1; when both would match, sel_zii SHALL win.

Reset
REQ-030 With _reset=0 at a clock edge, the state SHALL go to IDLE, and pend_lo, pend_hi, pend_z3, base_zii, base_ziii, sel_zii, sel_ziii, hit_valid and the board_configured copy SHALL all be cleared to 0.
REQ-031 Reset during LO_SEEN or ARMED SHALL discard the pending data; no commit SHALL occur on the first cycle after reset, even if board_configured=1.

Configuration
REQ-032 Macro MINIMIG_ZORRO3_DECODE_EN SHALL control ZIII support.
REQ-033 With the macro defined, REQ-019, REQ-022 and REQ-027 SHALL be active.
REQ-034 Without the macro, the 0x44 write SHALL be ignored, base_ziii SHALL be tied to 0, sel_ziii SHALL be tied to 0, and no pend_z3 register SHALL exist.

Verification
REQ-035 Test ZII commit: fastram_config=10; write 0x4A data 0x0000, then 0x48 data 0x2000; raise board_configured[0] -> base_zii=0x20 one cycle after the edge.
REQ-036 Test ZII decode: with base_zii=0x20 and 4 MB, request A=0x5FFFFE -> sel_zii=1 and hit_valid pulse; request A=0x600000 -> sel_zii=0; request A=0x1FFFFE -> sel_zii=0.
REQ-037 Test ZII wrap edge: fastram_config=11, base 0xC0; request A=0xFFFFFE -> sel_zii=1; request A=0x01000000 -> sel_zii=0.
REQ-038 Test ZIII (macro on): write 0x44 data 0x4000, raise board_configured[1] -> base_ziii=0x40; request A=0x40123456 -> sel_ziii=1, sel_zii=0.
REQ-039 Test simultaneous events: a board_configured[0] rise in the same cycle as a 0x48 write of 0x9000 -> commit uses the old pend_hi, and pend_hi then becomes 0x9.
REQ-040 Test reset mid-config: write 0x4A data 0x5000, assert _reset=0 for 1 cycle, write 0x48 data 0x2000, commit -> base_zii=0x20.
